mvm_seq_ctrl: RTL and testbench

MVM_SEQ_CTRL -- requirements
Module: mvm_seq_ctrl

---
 rtl/mvm_pkg.sv | 21 ++
 rtl/mvm_seq_ctrl_delay.sv | 25 ++
 rtl/mvm_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mvm_seq_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared types and latency helpers for the matrix-vector sequencer.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Issue-to-accumulator-input latency: BRAM read + multiplier + lane adder tree.
  function automatic int lat_in(input int delay_mul, input int delay_add);
    return 1 + delay_mul + delay_add;
  endfunction

  // Issue of a row's last beat to its result write.
  function automatic int wr_lat(input int delay_mul, input int delay_add, input int delay_acc);
    return lat_in(delay_mul, delay_add) + delay_acc;
  endfunction

endpackage

// File: rtl/mvm_seq_ctrl_delay.sv
// Fixed-depth shift register with synchronous clear; carries strobes alongside the datapath.
module mvm_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/mvm_seq_ctrl.sv
// Matrix-vector multiply sequencer: streams matrix/vector beats row by row, steers the
// accumulator strobes and writes one result word per row back into the vector BRAM.
module mvm_seq_ctrl
  import mvm_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int MADDR_W   = 12,
  parameter int VADDR_W   = 10,
  parameter int DIM_W     = 9,
  parameter int DELAY_MUL = 2,
  parameter int DELAY_ADD = 1,
  parameter int DELAY_ACC = 3,
  parameter int RES_BASE  = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   height,
  output logic               mbram_en,
  output logic [MADDR_W-1:0] mbram_addr,
  output logic               vbram_en,
  output logic               vbram_we,
  output logic [VADDR_W-1:0] vbram_addr,
  output logic               acc_en,
  output logic               zero_in,
  output logic               last,
  output logic               rows_done,
  output logic               busy,
  output logic               done
);

  if (LANES < 1 || LANES > 16) begin : g_lanes_check
    $error("mvm_seq_ctrl: LANES must be within 1..16");
  end

  // Outputs are registered, so both strobe lines are one stage longer/shorter than the
  // raw latency: the accumulator strobes come straight off the line, the write tap is
  // consumed one edge early so the write and the issue stall can be registered together.
  localparam int ACC_DLY = lat_in(DELAY_MUL, DELAY_ADD) + 1;
  localparam int WR_DLY  = wr_lat(DELAY_MUL, DELAY_ADD, DELAY_ACC);

  localparam logic [DIM_W-1:0]   DIM_ONE = DIM_W'(1);
  localparam logic [MADDR_W-1:0] MA_ONE  = MADDR_W'(1);

  state_t             state;
  logic [DIM_W-1:0]   w_reg, h_reg;
  logic [DIM_W-1:0]   col_cnt, row_cnt, wr_cnt;
  logic [MADDR_W-1:0] ma_cnt;

  logic               start_ok, issue, row_end, job_end;
  logic [DIM_W-1:0]   cur_w, cur_h, cur_c, cur_r;
  logic [MADDR_W-1:0] cur_ma;
  logic               wr_pend;
  logic [DIM_W-1:0]   wr_row;

  always_comb begin
    start_ok = (state == IDLE) && start && (width != '0) && (height != '0);
    // An accepted start issues beat (0,0) on the same edge, using the live dims.
    cur_w    = (state == IDLE) ? width  : w_reg;
    cur_h    = (state == IDLE) ? height : h_reg;
    cur_c    = (state == IDLE) ? '0 : col_cnt;
    cur_r    = (state == IDLE) ? '0 : row_cnt;
    cur_ma   = (state == IDLE) ? '0 : ma_cnt;
    issue    = start_ok || ((state == RUN) && !wr_pend);
    row_end  = issue && (cur_c == cur_w - DIM_ONE);
    job_end  = row_end && (cur_r == cur_h - DIM_ONE);
  end

  mvm_delay_line #(.DEPTH(ACC_DLY), .W(3)) u_acc_dly (
    .clk (clk),
    .clr (rst),
    .d   ({issue, issue && (cur_c == '0), row_end}),
    .q   ({acc_en, zero_in, last})
  );

  mvm_delay_line #(.DEPTH(WR_DLY), .W(DIM_W + 1)) u_wr_dly (
    .clk (clk),
    .clr (rst),
    .d   ({row_end, cur_r}),
    .q   ({wr_pend, wr_row})
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      w_reg      <= '0;
      h_reg      <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      wr_cnt     <= '0;
      ma_cnt     <= '0;
      mbram_en   <= 1'b0;
      mbram_addr <= '0;
      vbram_en   <= 1'b0;
      vbram_we   <= 1'b0;
      vbram_addr <= '0;
      rows_done  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mbram_en   <= 1'b0;
      mbram_addr <= '0;
      vbram_en   <= 1'b0;
      vbram_we   <= 1'b0;
      vbram_addr <= '0;
      rows_done  <= 1'b0;
      done       <= 1'b0;

      if (issue) begin
        mbram_en   <= 1'b1;
        mbram_addr <= cur_ma;
        vbram_en   <= 1'b1;
        vbram_addr <= VADDR_W'(cur_c);
        ma_cnt     <= cur_ma + MA_ONE;
        if (row_end) begin
          col_cnt <= '0;
          row_cnt <= cur_r + DIM_ONE;
        end else begin
          col_cnt <= cur_c + DIM_ONE;
          row_cnt <= cur_r;
        end
      end

      // Never overlaps an issue: RUN only issues when no write is due.
      if (wr_pend) begin
        vbram_en   <= 1'b1;
        vbram_we   <= 1'b1;
        vbram_addr <= VADDR_W'(RES_BASE) + VADDR_W'(wr_row);
        rows_done  <= 1'b1;
        wr_cnt     <= wr_cnt + DIM_ONE;
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            w_reg  <= width;
            h_reg  <= height;
            wr_cnt <= '0;
            busy   <= 1'b1;
            state  <= job_end ? DRAIN : RUN;
          end else if (start) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        RUN: begin
          if (job_end) state <= DRAIN;
        end
        DRAIN: begin
          if (rows_done && (wr_cnt == h_reg)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Scoreboard bench: a cycle schedule per job is queued at start, a negedge monitor compares every output cycle.
module tb_mvm_seq_ctrl;

  localparam int LAT_IN = 1 + 2 + 1;
  localparam int WR_LAT = LAT_IN + 3;
  localparam int RESB   = 512;
  localparam int TMAX   = 1024;

  typedef struct packed {
    logic        men;
    logic [11:0] maddr;
    logic        ven;
    logic        vwe;
    logic [9:0]  vaddr;
    logic        acc;
    logic        zero;
    logic        lst;
    logic        rd;
    logic        bsy;
    logic        dn;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [8:0]  width, height;
  logic        mbram_en, vbram_en, vbram_we, acc_en, zero_in, last, rows_done, busy, done;
  logic [11:0] mbram_addr;
  logic [9:0]  vbram_addr;

  mvm_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .width      (width),
    .height     (height),
    .mbram_en   (mbram_en),
    .mbram_addr (mbram_addr),
    .vbram_en   (vbram_en),
    .vbram_we   (vbram_we),
    .vbram_addr (vbram_addr),
    .acc_en     (acc_en),
    .zero_in    (zero_in),
    .last       (last),
    .rows_done  (rows_done),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  obs_t sb[$];
  obs_t tr[0:TMAX-1];
  int   wr_at[0:TMAX-1];
  int   tr_len;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  // Expected schedule: each cycle either hosts a due result write or issues the next beat.
  task automatic build(input int w, input int h);
    int bi, nb, t, lastw, r, c;
    for (int i = 0; i < TMAX; i++) begin
      tr[i]    = '0;
      wr_at[i] = -1;
    end
    if (w == 0 || h == 0) begin
      tr[1].dn = 1'b1;
      tr_len   = 2;
      return;
    end
    nb = w * h; bi = 0; t = 1; lastw = 0;
    while (bi < nb) begin
      if (wr_at[t] >= 0) begin
        tr[t].ven = 1'b1; tr[t].vwe = 1'b1; tr[t].rd = 1'b1;
        tr[t].vaddr = 10'(RESB + wr_at[t]);
        lastw = t;
      end else begin
        r = bi / w; c = bi % w;
        tr[t].men = 1'b1; tr[t].maddr = 12'(r * w + c);
        tr[t].ven = 1'b1; tr[t].vaddr = 10'(c);
        tr[t+LAT_IN].acc  = 1'b1;
        tr[t+LAT_IN].zero = (c == 0);
        tr[t+LAT_IN].lst  = (c == w - 1);
        if (c == w - 1) wr_at[t+WR_LAT] = r;
        bi++;
      end
      t++;
    end
    for (int tt = t; tt <= t + WR_LAT; tt++) begin
      if (wr_at[tt] >= 0) begin
        tr[tt].ven = 1'b1; tr[tt].vwe = 1'b1; tr[tt].rd = 1'b1;
        tr[tt].vaddr = 10'(RESB + wr_at[tt]);
        lastw = tt;
      end
    end
    for (int k = 1; k <= lastw; k++) tr[k].bsy = 1'b1;
    tr[lastw+1].dn = 1'b1;
    tr_len = lastw + 2;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      obs_t got, exp_o;
      got = {mbram_en, mbram_addr, vbram_en, vbram_we, vbram_addr,
             acc_en, zero_in, last, rows_done, busy, done};
      exp_o = (sb.size() != 0) ? sb.pop_front() : obs_t'('0);
      n_chk++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL outputs @%0t: got men=%b ma=%0d ven=%b we=%b va=%0d acc=%b z=%b l=%b rd=%b busy=%b done=%b, exp men=%b ma=%0d ven=%b we=%b va=%0d acc=%b z=%b l=%b rd=%b busy=%b done=%b",
                 $time, got.men, got.maddr, got.ven, got.vwe, got.vaddr, got.acc, got.zero, got.lst, got.rd, got.bsy, got.dn,
                 exp_o.men, exp_o.maddr, exp_o.ven, exp_o.vwe, exp_o.vaddr, exp_o.acc, exp_o.zero, exp_o.lst, exp_o.rd, exp_o.bsy, exp_o.dn);
      end
    end
  end

  // rst_at >= 0 asserts reset (with a start) in that cycle; the queue then stops there.
  task automatic run_job(input int w, input int h, input bit noise, input int rst_at);
    int last_k, b;
    build(w, h);
    @(posedge clk); #1;
    for (int k = 0; k < tr_len; k++) begin
      if (rst_at < 0 || k <= rst_at) sb.push_back(tr[k]);
    end
    width  = 9'(w);
    height = 9'(h);
    start  = 1'b1;
    last_k = (rst_at >= 0) ? rst_at + 1 : tr_len - 1;
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst   = 1'b0;
      if (k == rst_at) begin
        rst   = 1'b1;
        start = 1'b1;
      end else if (noise && k < tr_len - 1 && $urandom_range(0, 2) == 0) begin
        start  = 1'b1;
        width  = 9'($urandom_range(0, 7));
        height = 9'($urandom_range(0, 7));
      end
    end
    b = 0;
    while (sb.size() != 0 && b < 3000) begin
      @(posedge clk);
      b++;
    end
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; width = '0; height = '0;
    @(posedge clk); #1;
    mon_on = 1'b1;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_job(3, 2, 1'b0, -1);
    run_job(1, 10, 1'b0, -1);
    run_job(0, 5, 1'b0, -1);
    run_job(3, 2, 1'b0, 4);
    run_job(3, 2, 1'b0, -1);
    run_job(3, 2, 1'b1, -1);
    run_job(5, 0, 1'b1, -1);
    run_job(1, 1, 1'b0, -1);
    for (int j = 0; j < 30; j++) begin
      run_job(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)), -1);
    end
    @(negedge clk);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
